// File: rtl/mc_core_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mc_core_pkg : opcodes, FSM states and HALT encoding for mc_core
// Rev 1.0
// ------------------------------------------------------------------
package mc_core_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_XOR = 3'd3,
    OP_LDI = 3'd4,
    OP_LD  = 3'd5,
    OP_ST  = 3'd6,
    OP_BRZ = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  // HALT is the all-ones instruction word, IW = 3 + 2*RW bits wide.
  function automatic logic [31:0] halt_enc(input int unsigned rw);
    return (32'd1 << (3 + 2 * rw)) - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_core_alu.sv
`default_nettype none
// ------------------------------------------------------------------
// mc_alu : ADD/SUB/AND/XOR datapath with zero-detect on operand A
// Rev 1.0
// ------------------------------------------------------------------
module mc_alu
  import mc_core_pkg::*;
#(
  parameter int DW = 8
) (
  input  op_e           op_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] y_o,
  output logic          zero_o
);

  always_comb begin
    y_o = a_i;
    case (op_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      default: y_o = a_i;
    endcase
  end

  assign zero_o = (a_i == '0);

endmodule
`default_nettype wire

// File: rtl/mc_core.sv
`default_nettype none
// ------------------------------------------------------------------
// mc_core : multi-cycle load/store core with req/done handshake
// Rev 1.0
// ------------------------------------------------------------------
module mc_core
  import mc_core_pkg::*;
#(
  parameter int DW  = 8,
  parameter int PCW = 10,
  parameter int RW  = 3,
  parameter int CW  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  output logic              done,
  output logic [PCW-1:0]    imem_addr,
  input  logic [2*RW+2:0]   imem_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DW-1:0]     dmem_addr,
  output logic [DW-1:0]     dmem_wdata,
  input  logic [DW-1:0]     dmem_rdata,
  input  logic              dmem_ack,
  output logic [CW-1:0]     instr_cnt
);

  localparam int              IW         = 3 + 2 * RW;
  localparam int              NREG       = 1 << RW;
  localparam logic [31:0]     HALT_FULL  = halt_enc(RW);
  localparam logic [IW-1:0]   HALT_INSTR = HALT_FULL[IW-1:0];

  state_e           state_q;
  logic [PCW-1:0]   pc_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q;
  logic             dreq_q;
  logic             dwe_q;
  logic [DW-1:0]    daddr_q;
  logic [DW-1:0]    dwdata_q;
  logic [RW-1:0]    mrd_q;
  logic [DW-1:0]    rf_q [NREG];

  op_e              op;
  logic [RW-1:0]    rd_a;
  logic [RW-1:0]    rs_a;
  logic             is_halt;
  logic [DW-1:0]    rd_val;
  logic [DW-1:0]    rs_val;
  logic [DW-1:0]    imm_dw;
  logic [PCW-1:0]   imm_pc;
  logic [PCW-1:0]   pc_inc;
  logic [CW-1:0]    cnt_sat;
  logic [DW-1:0]    alu_y;
  logic             alu_zero;
  logic             rf_we;
  logic [RW-1:0]    rf_wa;
  logic [DW-1:0]    rf_wd;

  assign op      = op_e'(imem_data[IW-1:IW-3]);
  assign rd_a    = imem_data[2*RW-1:RW];
  assign rs_a    = imem_data[RW-1:0];
  assign is_halt = (imem_data == HALT_INSTR);
  assign rd_val  = rf_q[rd_a];
  assign rs_val  = rf_q[rs_a];
  assign imm_dw  = {{(DW-RW){rs_a[RW-1]}}, rs_a};
  assign imm_pc  = {{(PCW-RW){rs_a[RW-1]}}, rs_a};
  assign pc_inc  = pc_q + PCW'(1);
  assign cnt_sat = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

  mc_alu #(.DW(DW)) u_alu (
    .op_i   (op),
    .a_i    (rd_val),
    .b_i    (rs_val),
    .y_o    (alu_y),
    .zero_o (alu_zero)
  );

  // Loads write back on ack using the destination captured on MEM entry.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = rd_a;
    rf_wd = alu_y;
    if (state_q == ST_EXEC && !is_halt &&
        (op inside {OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_LDI})) begin
      rf_we = 1'b1;
      rf_wd = (op == OP_LDI) ? imm_dw : alu_y;
    end else if (state_q == ST_MEM && dmem_ack && !dwe_q) begin
      rf_we = 1'b1;
      rf_wa = mrd_q;
      rf_wd = dmem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rf_wa] <= rf_wd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      dreq_q   <= 1'b0;
      dwe_q    <= 1'b0;
      daddr_q  <= '0;
      dwdata_q <= '0;
      mrd_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            pc_q    <= '0;
            cnt_q   <= '0;
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: state_q <= ST_EXEC;
        ST_EXEC: begin
          if (is_halt) begin
            done_q  <= 1'b1;
            state_q <= ST_HALTED;
          end else begin
            case (op)
              OP_LD, OP_ST: begin
                dreq_q   <= 1'b1;
                dwe_q    <= (op == OP_ST);
                daddr_q  <= rs_val;
                dwdata_q <= rd_val;
                mrd_q    <= rd_a;
                state_q  <= ST_MEM;
              end
              OP_BRZ: begin
                pc_q    <= alu_zero ? pc_q + imm_pc : pc_inc;
                cnt_q   <= cnt_sat;
                state_q <= ST_FETCH;
              end
              default: begin
                pc_q    <= pc_inc;
                cnt_q   <= cnt_sat;
                state_q <= ST_FETCH;
              end
            endcase
          end
        end
        ST_MEM: begin
          if (dmem_ack) begin
            dreq_q  <= 1'b0;
            dwe_q   <= 1'b0;
            pc_q    <= pc_inc;
            cnt_q   <= cnt_sat;
            state_q <= ST_FETCH;
          end
        end
        ST_HALTED: begin
          if (!req) begin
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign done       = done_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dreq_q;
  assign dmem_we    = dwe_q;
  assign dmem_addr  = daddr_q;
  assign dmem_wdata = dwdata_q;
  assign instr_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: doc/mc_core.md
# mc_core

Parametrised multi-cycle successor to the single-cycle CPU top level. Fetches fixed-width instructions from an external synchronous instruction ROM and executes a compact load/store ISA. Data memory sits behind a request/acknowledge handshake, so memory may take any number of wait cycles. A `req`/`done` start handshake and a retired-instruction counter are included. Data width, register count and PC width are generics.

## Interface
- `DW`, 8, data/register width; also data-memory address width.
- `PCW`, 10, program counter width.
- `RW`, 3, register-address bits (2^RW registers); instruction width `IW = 3 + 2*RW`.
- `CW`, 16, retired-instruction counter width.
- `clk`  input  1  single clock, all state on rising edge.
- `reset`  input  1  asynchronous, active-low (0 = reset).
- `req`  input  1  start request, level.
- `done`  output  1  program halted; held until `req` low.
- `imem_addr`  output  PCW  instruction address (= PC).
- `imem_data`  input  IW  instruction, valid one cycle after `imem_addr`.
- `dmem_req`  output  1  data access request, held until ack.
- `dmem_we`  output  1  1 = store.
- `dmem_addr`  output  DW  data address.
- `dmem_wdata`  output  DW  store data.
- `dmem_rdata`  input  DW  load data, valid with ack.
- `dmem_ack`  input  1  one-cycle access completion.
- `instr_cnt`  output  CW  instructions retired since start, saturating.

## Operation
- Encoding: `op = instr[IW-1:IW-3]`, `rd = instr[2RW-1:RW]`, `rs/imm = instr[RW-1:0]`.
- Ops:
  - 0 ADD `rd += rs`.
  - 1 SUB `rd -= rs`.
  - 2 AND `rd &= rs`.
  - 3 XOR `rd ^= rs`.
  - 4 LDI `rd = sext(imm)`.
  - 5 LD `rd = mem[rs]`.
  - 6 ST `mem[rs] = rd`.
  - 7 BRZ: if `rd == 0` then `PC += sext(imm)`, else `PC += 1`.
- HALT is the all-ones encoding. It overrides BRZ.
- Arithmetic is modulo 2^DW. PC is modulo 2^PCW, and wraps from the top to 0.
- `dmem_addr` = `rs` value. `dmem_wdata` = `rd` value.
- States:
  - IDLE: `req` = 1 → PC = 0, `instr_cnt` = 0, go to FETCH.
  - FETCH: drive `imem_addr` = PC → EXEC.
  - EXEC: decode `imem_data`.
    - ALU/LDI: write `rd`, PC += 1 → FETCH.
    - BRZ: update PC → FETCH.
    - LD/ST → MEM.
    - HALT → HALTED.
  - MEM: `dmem_req` = 1, with `dmem_we`/`dmem_addr`/`dmem_wdata` stable.
    - On `dmem_ack`: LD writes `rd` from `dmem_rdata`; PC += 1 → FETCH.
  - HALTED: `done` = 1. When `req` = 0 → IDLE. `req` held high stays in HALTED (no auto-restart).
- `instr_cnt` increments on each retire: EXEC exit for non-memory ops, ack for memory ops. HALT does not count. Saturates at 2^CW-1.
- Registers keep their values across runs; only reset clears them.
- `dmem_ack` outside MEM is ignored.

## Timing
- Reset (async assert): state IDLE, PC 0, all registers 0, `instr_cnt` 0. All outputs 0, including `imem_addr` = 0. Synchronous deassert assumed by integrator.
- ALU/LDI/BRZ: 2 cycles per instruction.
- LD/ST: 2 + N cycles, where N ≥ 1 is cycles to ack. Ack in the first MEM cycle gives 3 cycles.
- `req` rising in IDLE: first `imem_addr` = 0 presented the next cycle (FETCH).
- `done` rises the cycle after EXEC decodes HALT. It falls the cycle after `req` is sampled 0.
- Reset mid-MEM: `dmem_req` drops immediately (async). No register write occurs.
- `dmem_req` never deasserts before ack. Outputs are registered or state-decoded, so they are glitch-free per cycle.

## Structure
- Package `mc_core_pkg`:
  - `op_e` opcode enum.
  - `state_e` (IDLE/FETCH/EXEC/MEM/HALTED).
  - Function returning the HALT encoding for a given RW.
- Sub-module `mc_alu`, parametrised by DW: ADD/SUB/AND/XOR plus a zero-detect output used by BRZ.
- Register file is inline; 2^RW × DW flops with async clear.

## Test plan
- ALU: program `LDI r1,3; LDI r2,-2; ADD r1,r2; HALT`, `req` = 1 → r1 = 1, `done` = 1, `instr_cnt` = 3, 8 cycles from start to `done`.
- Memory wait: ST r1→mem[r2] with ack after 4 wait cycles, then LD back into r3 → `dmem_req` held 4 cycles, r3 equals the stored value, `dmem_we` = 1 only on the store.
- Branch: BRZ on r0 = 0 with imm = -2 at PC 5 → next `imem_addr` = 3. Same with r0 ≠ 0 → `imem_addr` = 6. BRZ at PC 2^PCW-1 not taken wraps to 0.
- Handshake: hold `req` high after `done` → stays HALTED. Drop `req` → IDLE. Re-raise `req` → restart from PC 0 with registers preserved and `instr_cnt` cleared.
- Reset: assert `reset` = 0 during MEM with `dmem_req` = 1 → `dmem_req`/`done` = 0 immediately and state IDLE. A late `dmem_ack` after release is ignored.
- Saturation: CW = 4, 20-instruction loop → `instr_cnt` holds at 15.
